// File: rtl/bridge_pkg.sv
// Shared AHB-to-APB bridge definitions: FSM state encoding, HTRANS codes,
// APB slave address windows and the one-hot slave-select decode.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_e;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] S0_BASE  = 32'h8000_0000;
    localparam logic [31:0] S1_BASE  = 32'h8400_0000;
    localparam logic [31:0] S2_BASE  = 32'h8800_0000;
    localparam logic [31:0] S2_LIMIT = 32'h8C00_0000;

    localparam logic [2:0] SEL_S0 = 3'b001;
    localparam logic [2:0] SEL_S1 = 3'b010;
    localparam logic [2:0] SEL_S2 = 3'b100;

    // Addresses outside the bridge window select no slave at all.
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if (addr >= S0_BASE && addr < S1_BASE) begin
            sel = SEL_S0;
        end else if (addr >= S1_BASE && addr < S2_BASE) begin
            sel = SEL_S1;
        end else if (addr >= S2_BASE && addr < S2_LIMIT) begin
            sel = SEL_S2;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_master_fsm.sv
// APB-side sequencer of the AHB-to-APB bridge: setup/access phases, one pending
// pipelined write. Define APB_PREADY_EN to add pready-based access-phase wait states.
module apb_master_fsm
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata1,
    input  logic [NSLV-1:0]   temp_selx,
`ifdef APB_PREADY_EN
    input  logic              pready,
`endif
    output logic              pwrite,
    output logic              penable,
    output logic [NSLV-1:0]   pselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout
);

    state_e              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic                penable_q, penable_d;
    logic                hready_q, hready_d;
    logic [NSLV-1:0]     pselx_q, pselx_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                access_done;

`ifdef APB_PREADY_EN
    assign access_done = pready;
`else
    assign access_done = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        hready_d  = hready_q;
        pselx_d   = pselx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        wr_addr   = haddr1;
        wr_data   = hwdata;

        case (state_q)
            ST_IDLE: begin
                if (valid) state_d = hwrite ? ST_WWAIT : ST_READ;
            end
            ST_WWAIT:  state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:   state_d = ST_RENABLE;
            ST_WRITE:  state_d = ST_WENABLE;
            ST_WRITEP: state_d = ST_WENABLEP;
            ST_RENABLE, ST_WENABLE: begin
                if (access_done) begin
                    if (valid) state_d = hwrite ? ST_WWAIT : ST_READ;
                    else       state_d = ST_IDLE;
                end
            end
            ST_WENABLEP: begin
                // The absorbed write's address/data are now two/one cycles old.
                wr_addr = haddr2;
                wr_data = hwdata1;
                if (access_done) begin
                    if (!hwrite_reg) state_d = ST_READ;
                    else             state_d = valid ? ST_WRITEP : ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE, ST_WWAIT: begin
                pselx_d   = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
            ST_READ: begin
                pselx_d   = temp_selx;
                paddr_d   = haddr;
                pwrite_d  = 1'b0;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                pselx_d   = NSLV'(decode_sel(32'(wr_addr)));
                paddr_d   = wr_addr;
                pwdata_d  = wr_data;
                pwrite_d  = 1'b1;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            default: begin
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
            pselx_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            hready_q  <= hready_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign pwrite  = pwrite_q;
    assign penable = penable_q;
    assign pselx   = pselx_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
`ifdef APB_PREADY_EN
    // A stalled access phase must also stall the AHB master.
    assign hreadyout = hready_q & (pready | ~penable_q);
`else
    assign hreadyout = hready_q;
`endif

endmodule
